// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory write buffer.
//   WORD_BYTES   : byte lanes per RAM word
//   IDX_W        : stored word-index width; the largest AW the buffer supports
//   wbuf_entry_t : one buffered store, as presented to the forwarding mux
//   lane_merge   : byte-lane select between an old and a new word
package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = 16;

  typedef struct packed {
    logic                  valid;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           data;
    logic [WORD_BYTES-1:0] be;
  } wbuf_entry_t;

  // Lane i takes new_w when be[i] is set, otherwise keeps old_w.
  function automatic logic [31:0] lane_merge(input logic [31:0]           old_w,
                                             input logic [31:0]           new_w,
                                             input logic [WORD_BYTES-1:0] be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_wbuf_fifo.sv
// Circular store buffer for dmem_wbuf.
//   clk, reset          : clock, asynchronous active-high reset (clears pointers, count, valid bits)
//   push, push_*        : enqueue a store at the tail (ignored while full)
//   pop                 : dequeue the head (ignored while empty or when a push is taken)
//   head_*              : entry at the head, i.e. the next one to drain
//   age_entries         : all slots, [0] = youngest (tail-1) back to [DEPTH-1] = head side
//   full, empty         : occupancy flags derived from the separate count
module dmem_wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int AW    = 6,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [AW-1:0]                push_idx,
  input  logic [31:0]                  push_data,
  input  logic [WORD_BYTES-1:0]        push_be,
  input  logic                         pop,
  output logic [AW-1:0]                head_idx,
  output logic [31:0]                  head_data,
  output logic [WORD_BYTES-1:0]        head_be,
  output wbuf_entry_t [DEPTH-1:0]      age_entries,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [AW-1:0]         idx_q  [DEPTH];
  logic [31:0]           data_q [DEPTH];
  logic [WORD_BYTES-1:0] be_q   [DEPTH];
  logic                  do_push, do_pop;
  logic [PW-1:0]         slot;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  // The RAM port is shared, so a taken push always blocks the pop.
  assign do_pop  = pop && !empty && !do_push;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (do_push) begin
      tail_d          = tail_q + PW'(1);
      count_d         = count_q + CW'(1);
      valid_d[tail_q] = 1'b1;
    end else if (do_pop) begin
      head_d          = head_q + PW'(1);
      count_d         = count_q - CW'(1);
      valid_d[head_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset: a slot is only ever read through its valid bit.
  always_ff @(posedge clk) begin
    if (do_push) begin
      idx_q[tail_q]  <= push_idx;
      data_q[tail_q] <= push_data;
      be_q[tail_q]   <= push_be;
    end
  end

  assign head_idx  = idx_q[head_q];
  assign head_data = data_q[head_q];
  assign head_be   = be_q[head_q];

  always_comb begin
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot           = tail_q - PW'(k + 1);
      age_entries[k] = '{valid: valid_q[slot],
                         idx:   IDX_W'(idx_q[slot]),
                         data:  data_q[slot],
                         be:    be_q[slot]};
    end
  end

endmodule

// File: rtl/dmem_wbuf.sv
// Data-memory responder with a posted-store write buffer.
//   clk, reset : clock, asynchronous active-high reset (buffer state only; RAM keeps its contents)
//   MemWrite   : store request; accepted unless the buffer is full
//   be         : byte-lane enables of the store
//   ALUResult  : byte address; word index is ALUResult[AW+1:2]
//   WriteData  : lane-aligned store data
//   ReadData   : combinational load data, RAM merged with buffered stores
//   Stall      : store requested while the buffer is full (store not taken)
//   Empty      : no buffered stores
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int AW    = 6,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [31:0]           ALUResult,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Stall,
  output logic                  Empty
);

  logic [AW-1:0]              idx;
  logic                       full, accept, drain;
  logic [AW-1:0]              head_idx;
  logic [31:0]                head_data;
  logic [WORD_BYTES-1:0]      head_be;
  wbuf_entry_t [DEPTH-1:0]    age_entries;
  logic [31:0]                mem_q [2**AW];
  logic [31:0]                read_d;
  logic                       unused_addr;

  assign idx         = ALUResult[AW+1:2];
  assign unused_addr = ^{ALUResult[31:AW+2], ALUResult[1:0]};

  assign accept = MemWrite && !full;
  assign Stall  = MemWrite && full;
  // Drain whenever the RAM port is not taken by an accepted store.
  assign drain  = !Empty && !accept;

  dmem_wbuf_fifo #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (MemWrite),
    .push_idx    (idx),
    .push_data   (WriteData),
    .push_be     (be),
    .pop         (1'b1),
    .head_idx    (head_idx),
    .head_data   (head_data),
    .head_be     (head_be),
    .age_entries (age_entries),
    .full        (full),
    .empty       (Empty)
  );

  always_ff @(posedge clk) begin
    if (drain) begin
      mem_q[head_idx] <= lane_merge(mem_q[head_idx], head_data, head_be);
    end
  end

  // Walk entries oldest to youngest so the youngest matching lane ends up on top.
  always_comb begin
    read_d = mem_q[idx];
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (age_entries[k].valid && (age_entries[k].idx == IDX_W'(idx))) begin
        read_d = lane_merge(read_d, age_entries[k].data, age_entries[k].be);
      end
    end
  end

  assign ReadData = read_d;

endmodule

// File: tb/tb_dmem_wbuf.sv
module tb_dmem_wbuf;

  localparam int AW    = 6;
  localparam int DEPTH = 4;
  localparam int WORDS = 1 << AW;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [3:0]  be;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Empty;

  int total = 0;
  int bad   = 0;

  dmem_wbuf #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .be        (be),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Empty     (Empty)
  );

  always #5 clk = ~clk;

  // Reference: a word array plus an ordered list of pending stores.
  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  st_t         mq[$];
  logic [31:0] mmem [WORDS];

  function automatic logic [31:0] apply_be(input logic [31:0] w, input logic [31:0] d,
                                           input logic [3:0] b);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    logic [31:0] w;
    w = mmem[idx];
    foreach (mq[j]) if (mq[j].idx == idx) w = apply_be(w, mq[j].data, mq[j].be);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if ($isunknown(exp)) return;
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check at negedge against the model, advance the model, step.
  task automatic cyc(input logic mw, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd_o,
                     output logic st_o, output logic em_o);
    int   ix;
    st_t  s;
    MemWrite  = mw;
    be        = b;
    ALUResult = a;
    WriteData = d;
    @(negedge clk);
    rd_o = ReadData;
    st_o = Stall;
    em_o = Empty;
    ix   = int'(a[AW+1:2]);
    chk("model_rd", rd_o, m_read(ix));
    chk("model_stall", {31'b0, st_o}, {31'b0, mw && (mq.size() == DEPTH)});
    chk("model_empty", {31'b0, em_o}, {31'b0, mq.size() == 0});
    if (mw && mq.size() < DEPTH) begin
      s.idx = ix; s.data = d; s.be = b;
      mq.push_back(s);
    end else if (mq.size() > 0) begin
      s = mq.pop_front();
      mmem[s.idx] = apply_be(mmem[s.idx], s.data, s.be);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        mw;
    logic [3:0]  b;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        st;
    logic        em;
  } vec_t;

  vec_t tbl[24];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        st, em;
    logic [31:0] wdat [10];

    tbl[0]  = '{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h5A5A0004, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 4'h0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 4'h1, 32'h20, 32'h000000AA, 32'h11223344, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4'h2, 32'h20, 32'h0000BB00, 32'h112233AA, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 32'h20, 32'h0,        32'h1122BBAA, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 32'h20, 32'h0,        32'h1122BBAA, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 32'h20, 32'h0,        32'h1122BBAA, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 4'hF, 32'h30, 32'h1,        32'h5A5A000C, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 4'hF, 32'h30, 32'h2,        32'h00000001, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 32'h30, 32'h0,        32'h00000002, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 32'h30, 32'h0,        32'h00000002, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 32'h30, 32'h0,        32'h00000002, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 4'hF, 32'h00, 32'hA0,       32'h5A5A0000, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 4'hF, 32'h04, 32'hA1,       32'h5A5A0001, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 4'hF, 32'h08, 32'hA2,       32'h5A5A0002, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 4'hF, 32'h0C, 32'hA3,       32'h5A5A0003, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 4'hF, 32'h10, 32'hA4,       32'hDEADBEEF, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 4'hF, 32'h10, 32'hA4,       32'hDEADBEEF, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 4'h0, 32'h00, 32'h0,        32'h000000A0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 4'h0, 32'h10, 32'h0,        32'h000000A4, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 4'h0, 32'h10, 32'h0,        32'h000000A4, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 4'h0, 32'h10, 32'h0,        32'h000000A4, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 4'h0, 32'h10, 32'h0,        32'h000000A4, 1'b0, 1'b1};

    for (int i = 0; i < WORDS; i++) mmem[i] = 'x;

    // Reset state, with a store requested while reset is held.
    reset     = 1'b1;
    MemWrite  = 1'b1;
    be        = 4'hF;
    ALUResult = 32'h0;
    WriteData = 32'h0;
    #12;
    chk("reset_empty", {31'b0, Empty}, 32'd1);
    chk("reset_stall", {31'b0, Stall}, 32'd0);
    MemWrite = 1'b0;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Preload every RAM word through store/idle pairs.
    for (int i = 0; i < WORDS; i++) begin
      cyc(1'b1, 4'hF, i << 2, 32'h5A5A0000 + i, rd, st, em);
      cyc(1'b0, 4'h0, i << 2, 32'h0, rd, st, em);
    end
    cyc(1'b1, 4'hF, 32'h20, 32'h11223344, rd, st, em);
    cyc(1'b0, 4'h0, 32'h20, 32'h0, rd, st, em);

    // Directed vectors: visibility, byte merge, youngest-wins, fill/stall.
    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].mw, tbl[i].b, tbl[i].a, tbl[i].d, rd, st, em);
      chk($sformatf("vec%0d_rd", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_stall", i), {31'b0, st}, {31'b0, tbl[i].st});
      chk($sformatf("vec%0d_empty", i), {31'b0, em}, {31'b0, tbl[i].em});
    end

    // Asynchronous reset with three pending stores.
    cyc(1'b1, 4'hF, 32'h00, 32'hF0, rd, st, em);
    cyc(1'b1, 4'hF, 32'h04, 32'hF1, rd, st, em);
    cyc(1'b1, 4'hF, 32'h08, 32'hF2, rd, st, em);
    MemWrite  = 1'b0;
    ALUResult = 32'h04;
    #1;
    chk("pre_reset_empty", {31'b0, Empty}, 32'd0);
    chk("pre_reset_fwd", ReadData, 32'hF1);
    reset = 1'b1;
    #1;
    mq.delete();
    chk("async_reset_empty", {31'b0, Empty}, 32'd1);
    chk("async_reset_old", ReadData, 32'hA1);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 4'h0, 32'h00, 32'h0, rd, st, em);
    chk("post_reset_rd0", rd, 32'hA0);
    cyc(1'b0, 4'h0, 32'h08, 32'h0, rd, st, em);
    chk("post_reset_rd2", rd, 32'hA2);

    // Pointer wrap: store/idle pairs never build up occupancy.
    for (int i = 0; i < 10; i++) begin
      wdat[i] = $urandom;
      cyc(1'b1, 4'hF, (40 + i) << 2, wdat[i], rd, st, em);
      cyc(1'b0, 4'h0, (40 + i) << 2, 32'h0, rd, st, em);
      chk($sformatf("wrap%0d_fwd", i), rd, wdat[i]);
      chk($sformatf("wrap%0d_empty", i), {31'b0, Empty}, 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 4'h0, (40 + i) << 2, 32'h0, rd, st, em);
      chk($sformatf("wrap%0d_back", i), rd, wdat[i]);
    end

    // Random traffic on a small address window to exercise forwarding and stalls.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      cyc(($urandom_range(0, 99) < 60), 4'($urandom), a, $urandom, rd, st, em);
    end
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 4'h0, 32'($urandom_range(0, 7)) << 2, 32'h0, rd, st, em);
    chk("final_empty", {31'b0, Empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
